// File: rtl/pcw_pkg.sv
// Shared definitions for the PCW download arbiter: FSM state encoding and
// default boot-ROM geometry / execution address.
// Purely declarative; no latency, no backpressure.
package pcw_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BOOT_RD  = 3'd1,
        BOOT_WR  = 3'd2,
        BOOT_END = 3'd3,
        HPS      = 3'd4
    } pcw_state_e;

    localparam logic [15:0] BOOT_ROM_END_DEF = 16'd275;
    localparam logic [15:0] EXEC_ADDR_DEF    = 16'h0000;

    // True while the boot copy owns the download port.
    function automatic logic is_boot(input pcw_state_e s);
        return (s == BOOT_RD) || (s == BOOT_WR) || (s == BOOT_END);
    endfunction

endpackage

// File: rtl/pcw_boot_seq.sv
// Boot-copy byte counter and registered boot-ROM address generator.
// Latency: rom_addr_o updates on the edge that enters BOOT_RD (aligned with that state).
// Backpressure: none; driven purely by the arbiter's strobes.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clr_i          restart the copy at byte 0
//   adv_i          step to the next byte
//   rd_next_i      next state is BOOT_RD, so load the ROM address
//   idx_o          current byte index
//   last_o         current byte is the final one
//   rom_addr_o     registered ROM address
module pcw_boot_seq
    import pcw_pkg::*;
#(
    parameter logic [15:0] LAST_IDX = BOOT_ROM_END_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        adv_i,
    input  logic        rd_next_i,
    output logic [15:0] idx_o,
    output logic        last_o,
    output logic [15:0] rom_addr_o
);

    logic [15:0] idx_q, idx_d;
    logic [15:0] rom_addr_q;

    // The copy stops at LAST_IDX, so the increment never wraps.
    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = 16'd0;
        end else if (adv_i) begin
            idx_d = idx_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q      <= 16'd0;
            rom_addr_q <= 16'd0;
        end else begin
            idx_q <= idx_d;
            // Present the address for the byte about to be read so that the
            // synchronous ROM returns it during the following BOOT_WR cycle.
            if (rd_next_i) begin
                rom_addr_q <= idx_d;
            end
        end
    end

    assign idx_o      = idx_q;
    assign last_o     = (idx_q == LAST_IDX);
    assign rom_addr_o = rom_addr_q;

endmodule

// File: rtl/pcw_dn_arbiter.sv
// Arbitrates the core download port between the boot-ROM copy and HPS ioctl downloads.
// Latency: dn_go/busy/ioctl_wait/execute_* track the FSM state; dn_wr trails its source by one cycle.
// Backpressure: ioctl_wait holds off a matching HPS download while a boot copy is running.
//
// Ports:
//   clk_sys, reset                    clock, asynchronous active-high reset
//   boot_start                        one-cycle boot-copy request
//   rom_addr / rom_data               boot-ROM read port (data one cycle after address)
//   ioctl_*                           HPS download side (ioctl_wait is the hold-off)
//   dn_go/dn_wr/dn_addr/dn_data       core download port
//   execute_enable / execute_addr     one-cycle start request issued after the boot copy
//   busy / boot_done                  status
module pcw_dn_arbiter
    import pcw_pkg::*;
#(
    parameter logic [15:0] BOOT_ROM_END = BOOT_ROM_END_DEF,
    parameter logic [15:0] EXEC_ADDR    = EXEC_ADDR_DEF,
    parameter logic [7:0]  HPS_INDEX    = 8'd0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        boot_start,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [15:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    output logic        dn_go,
    output logic        dn_wr,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        execute_enable,
    output logic [15:0] execute_addr,
    output logic        busy,
    output logic        boot_done
);

    pcw_state_e  state_q, state_d;
    logic        pend_q, pend_d;

    logic        dn_go_q, dn_go_d;
    logic        dn_wr_q, dn_wr_d;
    logic [15:0] dn_addr_q, dn_addr_d;
    logic [7:0]  dn_data_q, dn_data_d;
    logic        ioctl_wait_q, ioctl_wait_d;
    logic        exec_en_q, exec_en_d;
    logic [15:0] exec_addr_q, exec_addr_d;
    logic        busy_q, busy_d;
    logic        boot_done_q, boot_done_d;

    logic        hps_match;
    logic        hps_wr_acc;
    logic        boot_accept;
    logic [15:0] idx;
    logic        last_byte;

    assign hps_match = ioctl_download && (ioctl_index == HPS_INDEX);

    pcw_boot_seq #(
        .LAST_IDX (BOOT_ROM_END)
    ) u_boot_seq (
        .clk_i      (clk_sys),
        .rst_i      (reset),
        .clr_i      (boot_accept),
        .adv_i      ((state_q == BOOT_WR) && (state_d == BOOT_RD)),
        .rd_next_i  (state_d == BOOT_RD),
        .idx_o      (idx),
        .last_o     (last_byte),
        .rom_addr_o (rom_addr)
    );

    // Next-state logic. A boot request seen during HPS is parked in pend_q and
    // serviced from IDLE, so the HPS transfer is never cut short.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        boot_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (boot_start || pend_q) begin
                    state_d     = BOOT_RD;
                    pend_d      = 1'b0;
                    boot_accept = 1'b1;
                end else if (hps_match) begin
                    state_d = HPS;
                end
            end
            BOOT_RD:  state_d = BOOT_WR;
            BOOT_WR:  state_d = last_byte ? BOOT_END : BOOT_RD;
            BOOT_END: state_d = IDLE;
            HPS: begin
                if (boot_start) begin
                    pend_d = 1'b1;
                end
                if (!ioctl_download) begin
                    state_d = IDLE;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    // HPS writes are taken in HPS, or in IDLE when HPS is about to be entered
    // (ioctl_wait is already low there). A write immediately following another
    // is dropped so dn_wr can never be high on two consecutive cycles.
    assign hps_wr_acc = hps_match && ioctl_wr && !dn_wr_q &&
                        ((state_q == HPS) || ((state_q == IDLE) && (state_d == HPS)));

    // Output next-state: state-level outputs decode state_d so the registered
    // value lines up with the state itself; write strobes are one cycle behind
    // their source because the ROM byte is only valid during BOOT_WR.
    always_comb begin
        dn_go_d      = (state_d == BOOT_RD) || (state_d == BOOT_WR) || (state_d == HPS);
        busy_d       = (state_d != IDLE);
        exec_en_d    = (state_d == BOOT_END);
        exec_addr_d  = (state_d == BOOT_END) ? EXEC_ADDR : exec_addr_q;
        ioctl_wait_d = hps_match && is_boot(state_d);

        boot_done_d = boot_done_q;
        if (boot_accept) begin
            boot_done_d = 1'b0;
        end
        if (state_d == BOOT_END) begin
            boot_done_d = 1'b1;
        end

        dn_wr_d   = 1'b0;
        dn_addr_d = dn_addr_q;
        dn_data_d = dn_data_q;
        if (state_q == BOOT_WR) begin
            dn_wr_d   = 1'b1;
            dn_addr_d = idx;
            dn_data_d = rom_data;
        end else if (hps_wr_acc) begin
            dn_wr_d   = 1'b1;
            dn_addr_d = ioctl_addr;
            dn_data_d = ioctl_data;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_q       <= 1'b0;
            dn_go_q      <= 1'b0;
            dn_wr_q      <= 1'b0;
            dn_addr_q    <= 16'd0;
            dn_data_q    <= 8'd0;
            ioctl_wait_q <= 1'b0;
            exec_en_q    <= 1'b0;
            exec_addr_q  <= 16'd0;
            busy_q       <= 1'b0;
            boot_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            dn_go_q      <= dn_go_d;
            dn_wr_q      <= dn_wr_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
            ioctl_wait_q <= ioctl_wait_d;
            exec_en_q    <= exec_en_d;
            exec_addr_q  <= exec_addr_d;
            busy_q       <= busy_d;
            boot_done_q  <= boot_done_d;
        end
    end

    assign dn_go          = dn_go_q;
    assign dn_wr          = dn_wr_q;
    assign dn_addr        = dn_addr_q;
    assign dn_data        = dn_data_q;
    assign ioctl_wait     = ioctl_wait_q;
    assign execute_enable = exec_en_q;
    assign execute_addr   = exec_addr_q;
    assign busy           = busy_q;
    assign boot_done      = boot_done_q;

endmodule

// File: tb/tb_pcw_dn_arbiter.sv
// Testbench for pcw_dn_arbiter: boot copy, HPS downloads, hold-off, pending boot,
// mid-copy reset and foreign-index downloads, checked through a write/execute scoreboard.
module tb_pcw_dn_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        boot_start = 1'b0;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data = 8'd0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [15:0] ioctl_addr = 16'd0;
    logic [7:0]  ioctl_data = 8'd0;
    logic        ioctl_wait;
    logic        dn_go, dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        execute_enable;
    logic [15:0] execute_addr;
    logic        busy, boot_done;

    pcw_dn_arbiter #(
        .BOOT_ROM_END (16'd275),
        .EXEC_ADDR    (16'h0000),
        .HPS_INDEX    (8'd0)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .boot_start     (boot_start),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .dn_go          (dn_go),
        .dn_wr          (dn_wr),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .execute_enable (execute_enable),
        .execute_addr   (execute_addr),
        .busy           (busy),
        .boot_done      (boot_done)
    );

    always #5 clk_sys = ~clk_sys;

    // Boot-ROM contents: an arbitrary address hash so every byte is distinct-ish.
    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        return a[7:0] * 8'd7 + a[15:8] + 8'h3C;
    endfunction

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk_sys) rom_data <= rom_fn(rom_addr);

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_exec[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc;
    logic        prev_wr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe and execute pulse is matched against the scoreboard.
    always @(negedge clk_sys) begin
        wr_t e;
        if (dn_wr) begin
            chk("dn_wr_spacing", {31'd0, prev_wr}, 32'd0);
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dn_wr_unexpected: got addr %0h data %0h, required no write", dn_addr, dn_data);
            end else begin
                e = exp_wr.pop_front();
                chk("dn_addr", {16'd0, dn_addr}, {16'd0, e.addr});
                chk("dn_data", {24'd0, dn_data}, {24'd0, e.data});
            end
        end
        prev_wr = dn_wr;
        if (execute_enable) begin
            if (exp_exec.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL exec_unexpected: got execute_enable at addr %0h, required none", execute_addr);
            end else begin
                chk("execute_addr", {16'd0, execute_addr}, {16'd0, exp_exec.pop_front()});
            end
        end
    end

    task automatic push_boot(input int nbytes);
        wr_t e;
        for (int i = 0; i < nbytes; i++) begin
            e.addr = 16'(i);
            e.data = rom_fn(16'(i));
            exp_wr.push_back(e);
        end
    endtask

    // Pulses boot_start for one cycle; returns at the negedge of cycle 1 (first BOOT_RD).
    task automatic start_boot();
        boot_start = 1'b1;
        @(negedge clk_sys);
        boot_start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dn_go"},     {31'd0, dn_go}, 32'd0);
        chk({tag, "_dn_wr"},     {31'd0, dn_wr}, 32'd0);
        chk({tag, "_dn_addr"},   {16'd0, dn_addr}, 32'd0);
        chk({tag, "_dn_data"},   {24'd0, dn_data}, 32'd0);
        chk({tag, "_rom_addr"},  {16'd0, rom_addr}, 32'd0);
        chk({tag, "_wait"},      {31'd0, ioctl_wait}, 32'd0);
        chk({tag, "_exec_en"},   {31'd0, execute_enable}, 32'd0);
        chk({tag, "_exec_addr"}, {16'd0, execute_addr}, 32'd0);
        chk({tag, "_busy"},      {31'd0, busy}, 32'd0);
        chk({tag, "_boot_done"}, {31'd0, boot_done}, 32'd0);
    endtask

    task automatic wait_exec();
        while (!execute_enable && cyc < 2000) begin
            @(negedge clk_sys);
            cyc++;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_sys);
        chk_all_zero("rst");
        reset = 1'b0;
        @(negedge clk_sys);

        // Full boot copy: 276 bytes, execute at cycle 553
        push_boot(276);
        exp_exec.push_back(16'h0000);
        start_boot();
        cyc = 1;
        chk("boot_busy", {31'd0, busy}, 32'd1);
        chk("boot_go", {31'd0, dn_go}, 32'd1);
        chk("boot_rom_addr0", {16'd0, rom_addr}, 32'd0);
        wait_exec();
        chk("boot_exec_cycle", cyc, 553);
        chk("boot_end_go", {31'd0, dn_go}, 32'd0);
        @(negedge clk_sys);
        chk("boot_done_set", {31'd0, boot_done}, 32'd1);
        chk("boot_idle_busy", {31'd0, busy}, 32'd0);
        chk("boot_drain", exp_wr.size(), 0);

        // HPS download, four writes to 0x0100..0x0103
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("hps_go", {31'd0, dn_go}, 32'd1);
        chk("hps_wait", {31'd0, ioctl_wait}, 32'd0);
        chk("hps_boot_done_kept", {31'd0, boot_done}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            wr_t e;
            ioctl_addr = 16'h0100 + 16'(k);
            ioctl_data = 8'hA5 ^ 8'(k * 17);
            ioctl_wr = 1'b1;
            e.addr = ioctl_addr;
            e.data = ioctl_data;
            exp_wr.push_back(e);
            @(negedge clk_sys);
            ioctl_wr = 1'b0;
            chk("hps_wr_latency", {31'd0, dn_wr}, 32'd1);
            @(negedge clk_sys);
            chk("hps_wr_single", {31'd0, dn_wr}, 32'd0);
        end
        chk("hps_go_before_fall", {31'd0, dn_go}, 32'd1);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk("hps_go_fall", {31'd0, dn_go}, 32'd0);
        chk("hps_busy_fall", {31'd0, busy}, 32'd0);
        chk("hps_drain", exp_wr.size(), 0);

        // HPS download raised at byte 10 of a boot copy: held off until BOOT_END
        push_boot(276);
        exp_exec.push_back(16'h0000);
        start_boot();
        cyc = 1;
        while (!execute_enable && cyc < 2000) begin
            if (cyc >= 22) chk("wait_during_boot", {31'd0, ioctl_wait}, 32'd1);
            else           chk("wait_before_dl", {31'd0, ioctl_wait}, 32'd0);
            ioctl_wr = (cyc == 30) || (cyc == 31);
            ioctl_addr = 16'hDEAD;
            ioctl_data = 8'h11;
            if (cyc == 21) begin
                ioctl_index = 8'd0;
                ioctl_download = 1'b1;
            end
            @(negedge clk_sys);
            cyc++;
        end
        chk("hold_exec_cycle", cyc, 553);
        chk("wait_at_boot_end", {31'd0, ioctl_wait}, 32'd1);
        @(negedge clk_sys);
        chk("wait_idle", {31'd0, ioctl_wait}, 32'd0);
        chk("hold_idle_go", {31'd0, dn_go}, 32'd0);
        @(negedge clk_sys);
        chk("hold_hps_go", {31'd0, dn_go}, 32'd1);
        begin
            wr_t e;
            ioctl_addr = 16'h0200;
            ioctl_data = 8'hC3;
            ioctl_wr = 1'b1;
            e.addr = 16'h0200;
            e.data = 8'hC3;
            exp_wr.push_back(e);
        end
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        chk("hold_first_wr", {31'd0, dn_wr}, 32'd1);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk("hold_drain", exp_wr.size(), 0);

        // boot_start during HPS becomes pending and runs on IDLE entry
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        push_boot(276);
        exp_exec.push_back(16'h0000);
        start_boot();
        chk("pend_still_hps", {31'd0, dn_go}, 32'd1);
        chk("pend_boot_done_kept", {31'd0, boot_done}, 32'd1);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        cyc = 0;
        while (!execute_enable && cyc < 2000) begin
            @(negedge clk_sys);
            cyc++;
            if (cyc == 1) chk("pend_idle_busy", {31'd0, busy}, 32'd0);
            if (cyc == 2) begin
                chk("pend_boot_busy", {31'd0, busy}, 32'd1);
                chk("pend_boot_done_clr", {31'd0, boot_done}, 32'd0);
            end
        end
        chk("pend_exec_cycle", cyc, 554);
        @(negedge clk_sys);
        chk("pend_drain", exp_wr.size(), 0);

        // Reset at byte 100: bytes 0..99 written, nothing after
        push_boot(100);
        start_boot();
        cyc = 1;
        while (cyc < 202) begin
            @(negedge clk_sys);
            cyc++;
        end
        reset = 1'b1;
        #1;
        chk_all_zero("midrst");
        repeat (3) @(negedge clk_sys);
        chk("midrst_drain", exp_wr.size(), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        push_boot(276);
        exp_exec.push_back(16'h0000);
        start_boot();
        cyc = 1;
        chk("restart_rom_addr0", {16'd0, rom_addr}, 32'd0);
        wait_exec();
        chk("restart_exec_cycle", cyc, 553);
        @(negedge clk_sys);
        chk("restart_drain", exp_wr.size(), 0);

        // Foreign index: never touches dn_* or ioctl_wait
        ioctl_index = 8'd1;
        ioctl_download = 1'b1;
        ioctl_addr = 16'h0300;
        ioctl_data = 8'h77;
        for (int k = 0; k < 8; k++) begin
            ioctl_wr = k[0];
            @(negedge clk_sys);
            chk("idx1_go", {31'd0, dn_go}, 32'd0);
            chk("idx1_wait", {31'd0, ioctl_wait}, 32'd0);
            chk("idx1_busy", {31'd0, busy}, 32'd0);
        end
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("final_wr_drain", exp_wr.size(), 0);
        chk("final_exec_drain", exp_exec.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcw_dn_arbiter.md
PCW_DN_ARBITER -- requirements
Module: pcw_dn_arbiter

Interface
REQ-001 SHALL have parameter BOOT_ROM_END, default 16'd275, last boot-ROM byte address copied (inclusive).
REQ-002 SHALL have parameter EXEC_ADDR, default 16'h0000, start address reported at end of boot copy.
REQ-003 SHALL have parameter HPS_INDEX, default 8'd0, ioctl_index value accepted as a core download.
REQ-004 SHALL have ports: clk_sys in 1 system clock; reset in 1 asynchronous active-high reset (one clock, reset asynchronous and active-high).
REQ-005 SHALL have ports: boot_start in 1 one-cycle request to start boot copy; rom_addr out 16 boot-ROM address; rom_data in 8 ROM byte, valid one cycle after rom_addr.
REQ-006 SHALL have ports: ioctl_download in 1, ioctl_index in 8, ioctl_wr in 1, ioctl_addr in 16, ioctl_data in 8, ioctl_wait out 1 (HPS download side).
REQ-007 SHALL have ports: dn_go out 1, dn_wr out 1, dn_addr out 16, dn_data out 8 (core download port); execute_enable out 1; execute_addr out 16; busy out 1; boot_done out 1.

Function
REQ-008 SHALL implement FSM states IDLE, BOOT_RD, BOOT_WR, BOOT_END, HPS.
REQ-009 IDLE: boot_start -> BOOT_RD with byte counter idx=0; else ioctl_download with ioctl_index==HPS_INDEX -> HPS; boot_start wins if both in same cycle.
REQ-010 BOOT_RD: rom_addr=idx, dn_wr=0, next state BOOT_WR.
REQ-011 BOOT_WR: dn_wr=1, dn_addr=idx, dn_data=rom_data for exactly one cycle; if idx==BOOT_ROM_END -> BOOT_END, else idx+1 and -> BOOT_RD.
REQ-012 Boot copy SHALL transfer BOOT_ROM_END+1 bytes at 2 cycles per byte; dn_go=1 throughout BOOT_RD/BOOT_WR.
REQ-013 BOOT_END: dn_go=0, execute_enable=1 for exactly one cycle, execute_addr=EXEC_ADDR, boot_done set, -> IDLE.
REQ-014 boot_done SHALL stay set until the next accepted boot_start or reset.
REQ-015 HPS: dn_go=1; each ioctl_wr pulse SHALL produce one dn_wr pulse one cycle later with registered ioctl_addr/ioctl_data; exit to IDLE when ioctl_download falls.
REQ-016 ioctl_wait SHALL be 1 whenever ioctl_download==1, ioctl_index==HPS_INDEX and state is BOOT_RD, BOOT_WR or BOOT_END; else 0.
REQ-017 ioctl_wr while ioctl_wait==1 SHALL be ignored (no dn_wr).
REQ-018 Downloads with ioctl_index!=HPS_INDEX SHALL never drive dn_* nor raise ioctl_wait.
REQ-019 boot_start during BOOT_* SHALL be ignored; boot_start during HPS SHALL set a pending flag, and boot copy SHALL begin in the cycle IDLE is re-entered.
REQ-020 busy SHALL equal (state!=IDLE).
REQ-021 idx SHALL be 16 bits; no wrap occurs since copy stops at BOOT_ROM_END.
REQ-022 dn_wr SHALL never be high two consecutive cycles.

Reset
REQ-023 reset SHALL asynchronously force IDLE, idx=0, pending=0, and all outputs to 0 (dn_go, dn_wr, dn_addr, dn_data, rom_addr, ioctl_wait, execute_enable, execute_addr, busy, boot_done).
REQ-024 Reset mid-copy SHALL abort without further dn_wr or execute_enable; a fresh boot_start restarts from idx=0.

Structure
REQ-025 FSM state enum and default BOOT_ROM_END/EXEC_ADDR constants SHALL live in shared package pcw_pkg.
REQ-026 One sub-module is natural: pcw_boot_seq (BOOT_RD/BOOT_WR counter and ROM addressing); arbitration stays in top.
REQ-027 All outputs SHALL be registered.

Verification
REQ-028 boot_start after reset, BOOT_ROM_END=275 -> 276 dn_wr pulses, dn_addr 0..275 matching ROM model, one execute_enable with execute_addr=0 at cycle 553, boot_done=1.
REQ-029 HPS download index 0, 4 writes to 0x0100..0x0103 -> 4 dn_wr one cycle after each ioctl_wr with same addr/data; dn_go falls the cycle after ioctl_download falls.
REQ-030 ioctl_download index 0 raised at byte 10 of boot copy -> ioctl_wait=1 until BOOT_END, no dn_wr from HPS; HPS then accepted, first write lands correctly.
REQ-031 boot_start during HPS download -> pending; boot copy starts on IDLE entry, completes 276 bytes.
REQ-032 reset asserted at byte 100 of boot copy -> all outputs 0 immediately, no execute_enable; subsequent boot_start copies from address 0.
REQ-033 ioctl_index=1 download with ioctl_wr pulses -> no dn_go, no dn_wr, ioctl_wait=0.
